jtdd_colmix: RTL and testbench
==============================

JTDD_COLMIX -- requirements
Module: jtdd_colmix

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset, asynchronous, active-low.
REQ-002 SHALL have pxl_cen in 1, the pixel clock enable, and cen_E in 1, the CPU bus enable.
REQ-003 SHALL have cpu_AB in 10: bit 9 is the bank (0=RG, 1=B); bits 8:0 are the palette entry.
REQ-004 SHALL have pal_cs in 1 (palette select), cpu_wrn in 1 (write strobe, active-low) and cpu_dout in 8 (CPU write data).
REQ-005 SHALL have pal_dout out 8: CPU read data.
REQ-006 SHALL have char_pxl in 7 ({pal[2:0],pix[3:0]}), obj_pxl in 7 ({pal[2:0],pix[3:0]}) and scr_pxl in 8 ({prio,pal[2:0],pix[3:0]}).
REQ-007 SHALL have LHBL in 1 and LVBL in 1: horizontal and vertical blank, active-low, aligned with the pixel inputs.
REQ-008 SHALL have red out 4, green out 4 and blue out 4 (final colour), plus LHBL_dly out 1 and LVBL_dly out 1 (blanks aligned to the colour outputs).

Function
REQ-009 SHALL use a palette of 384 entries per bank; indices 0x180-0x1FF SHALL be storage only and never selected by video.
REQ-010 SHALL treat a layer as transparent when its pix[3:0]==0.
REQ-011 SHALL resolve priority, highest first:
  - char opaque -> index {2'b00,char_pxl}
  - scr_pxl[7]=1 and scroll opaque -> index {2'b10,scr_pxl[6:0]}
  - obj opaque -> index {2'b01,obj_pxl}
  - otherwise -> index {2'b10,scr_pxl[6:0]}; scroll colour 0 is drawn.
REQ-012 SHALL advance every pipeline register only on clk edges with pxl_cen=1.
REQ-013 SHALL register the selected index in stage 1, read both banks in stage 2, and register the outputs in stage 3: total latency 3 pxl_cen ticks.
REQ-014 SHALL delay LHBL and LVBL by exactly 3 pxl_cen ticks to produce LHBL_dly and LVBL_dly.
REQ-015 SHALL drive red=RG[3:0], green=RG[7:4] and blue=B[3:0] in stage 3 when both delayed blanks are 1, and drive 0 on all three otherwise.
REQ-016 SHALL write the addressed bank on a clk edge when pal_cs=1, cpu_wrn=0 and cen_E=1; B bank stores cpu_dout[3:0].
REQ-017 SHALL return pal_dout as the RG byte or {4'hF,B nibble} for the addressed entry, valid one cen_E cycle after pal_cs is asserted.
REQ-018 SHALL give each bank a CPU port and a video port on the dual-port RAM; CPU access never stalls video.
REQ-019 SHALL, when the CPU writes the entry video reads on the same edge, return the old data to video (read-first); the new data is visible from the next read.
REQ-020 SHALL hold all outputs and pipeline contents while pxl_cen=0, including during CPU writes.

Reset
REQ-021 SHALL, while rst=0, force red/green/blue=0, LHBL_dly=LVBL_dly=0, and clear all pipeline index registers to 0.
REQ-022 SHALL leave palette RAM contents unchanged by reset.
REQ-023 SHALL, on rst release mid-frame, produce valid colour no earlier than the 3rd pxl_cen tick with LHBL=LVBL=1; outputs stay blanked until then.

Structure
REQ-024 SHALL place the layer codes (CHAR=2'b00, OBJ=2'b01, SCR=2'b10), PAL_LATENCY=3 and bank bit position in the shared jtdd package.
REQ-025 SHALL instantiate jtframe_dual_ram twice (aw=9, dw=8), one per bank; priority and pipeline logic SHALL stay in jtdd_colmix.

Verification
REQ-026 SHALL cover write RG[0x105]=0x3A and B[0x105]=0x07, then scr_pxl=0x05, char/obj=0, blanks=1 -> after 3 pxl_cen ticks red=0xA, green=0x3, blue=0x7.
REQ-027 SHALL cover char_pxl=0x12, obj_pxl=0x23, scr_pxl=0xB4 -> index 0x012 output; then char_pxl=0x10 -> index 0x134 output (scroll priority over object).
REQ-028 SHALL cover scr_pxl=0x34 (prio=0), obj_pxl=0x23 -> index 0x0A3; then obj_pxl=0x20 -> index 0x134.
REQ-029 SHALL cover LHBL falling at tick N -> red/green/blue=0 and LHBL_dly=0 from tick N+3; both restore at N+3 after rising.
REQ-030 SHALL cover a CPU write of RG[0x012]=0xFF on the edge video reads 0x012 (old 0x00) -> that pixel shows 0, the next pixel shows red=0xF and green=0xF; pal_dout=0xFF on readback.
REQ-031 SHALL cover asserting rst mid-line -> outputs 0 immediately and RAM intact; after release, the REQ-026 pixel reproduces after 3 ticks.

Source files
------------

// File: rtl/jtdd_colmix_pkg.sv
// Shared definitions for the jtdd colour mixer: layer codes, palette geometry
// and the helper that forms a palette index from a layer code and pixel.
package jtdd_colmix_pkg;

    localparam int unsigned PAL_AW      = 9;
    localparam int unsigned PAL_DW      = 8;
    localparam int unsigned CPU_AW      = 10;
    localparam int unsigned BANK_BIT    = 9;
    localparam int unsigned PAL_LATENCY = 3;

    typedef enum logic [1:0] {
        LAYER_CHAR = 2'b00,
        LAYER_OBJ  = 2'b01,
        LAYER_SCR  = 2'b10
    } layer_e;

    typedef struct packed {
        logic [2:0] pal;
        logic [3:0] pix;
    } lyr_pxl_t;

    typedef struct packed {
        logic       prio;
        logic [2:0] pal;
        logic [3:0] pix;
    } scr_pxl_t;

    function automatic logic [PAL_AW-1:0] pal_idx(input layer_e layer, input logic [6:0] pxl);
        return {layer, pxl};
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 read/write (CPU), port 1 read-only (video).
// Both reads are read-first with respect to a same-edge write.
module jtframe_dual_ram #(
    parameter int unsigned aw = 9,
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          cen0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic          cen1,
    input  logic [aw-1:0] addr1,
    output logic [dw-1:0] q1
);

    localparam int unsigned DEPTH = 1 << aw;

    logic [dw-1:0] r_mem [DEPTH];

    // Contents are never reset; non-blocking write keeps both reads read-first
    always_ff @(posedge clk) begin
        if (cen0) q0 <= r_mem[addr0];
        if (cen1) q1 <= r_mem[addr1];
        if (we0)  r_mem[addr0] <= data0;
    end

endmodule

// File: rtl/jtdd_colmix.sv
// jtdd colour mixer: layer priority, two-bank palette lookup and a
// three-tick pixel pipeline with matching blank delay.
module jtdd_colmix
    import jtdd_colmix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pxl_cen,
    input  logic              cen_E,
    input  logic [CPU_AW-1:0] cpu_AB,
    input  logic              pal_cs,
    input  logic              cpu_wrn,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        pal_dout,
    input  logic [6:0]        char_pxl,
    input  logic [6:0]        obj_pxl,
    input  logic [7:0]        scr_pxl,
    input  logic              LHBL,
    input  logic              LVBL,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              LHBL_dly,
    output logic              LVBL_dly
);

    lyr_pxl_t               w_char;
    lyr_pxl_t               w_obj;
    scr_pxl_t               w_scr;
    logic [PAL_AW-1:0]      w_idx;
    logic [PAL_AW-1:0]      r_idx;
    logic [PAL_LATENCY-1:0] r_hbl;
    logic [PAL_LATENCY-1:0] r_vbl;
    logic [PAL_DW-1:0]      w_rg_cq;
    logic [PAL_DW-1:0]      w_rg_vq;
    logic [PAL_DW-1:0]      w_b_cq;
    logic [PAL_DW-1:0]      w_b_vq;
    logic                   w_we;
    logic                   w_we_rg;
    logic                   w_we_b;
    logic                   r_bank;
    logic                   w_unused_b;

    assign w_char = char_pxl;
    assign w_obj  = obj_pxl;
    assign w_scr  = scr_pxl;

    // Layer priority: char, then prioritised scroll, then object, else scroll (colour 0 drawn)
    always_comb begin
        w_idx = pal_idx(LAYER_SCR, {w_scr.pal, w_scr.pix});
        if (w_char.pix != 4'd0) begin
            w_idx = pal_idx(LAYER_CHAR, w_char);
        end else if (w_scr.prio && (w_scr.pix != 4'd0)) begin
            w_idx = pal_idx(LAYER_SCR, {w_scr.pal, w_scr.pix});
        end else if (w_obj.pix != 4'd0) begin
            w_idx = pal_idx(LAYER_OBJ, w_obj);
        end
    end

    assign w_we    = pal_cs & ~cpu_wrn & cen_E;
    assign w_we_rg = w_we & ~cpu_AB[BANK_BIT];
    assign w_we_b  = w_we &  cpu_AB[BANK_BIT];

    jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW)) u_pal_rg (
        .clk   (clk),
        .cen0  (cen_E),
        .data0 (cpu_dout),
        .addr0 (cpu_AB[PAL_AW-1:0]),
        .we0   (w_we_rg),
        .q0    (w_rg_cq),
        .cen1  (pxl_cen),
        .addr1 (r_idx),
        .q1    (w_rg_vq)
    );

    jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW)) u_pal_b (
        .clk   (clk),
        .cen0  (cen_E),
        .data0 ({4'h0, cpu_dout[3:0]}),
        .addr0 (cpu_AB[PAL_AW-1:0]),
        .we0   (w_we_b),
        .q0    (w_b_cq),
        .cen1  (pxl_cen),
        .addr1 (r_idx),
        .q1    (w_b_vq)
    );

    // Only the low nibble of the blue bank is meaningful
    assign w_unused_b = ^{w_b_cq[7:4], w_b_vq[7:4]};

    // Stage 1 index, blank delay line, stage 3 colour outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            r_hbl <= '0;
            r_vbl <= '0;
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else if (pxl_cen) begin
            r_idx <= w_idx;
            r_hbl <= {r_hbl[PAL_LATENCY-2:0], LHBL};
            r_vbl <= {r_vbl[PAL_LATENCY-2:0], LVBL};
            if (r_hbl[PAL_LATENCY-2] && r_vbl[PAL_LATENCY-2]) begin
                red   <= w_rg_vq[3:0];
                green <= w_rg_vq[7:4];
                blue  <= w_b_vq[3:0];
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
        end
    end

    assign LHBL_dly = r_hbl[PAL_LATENCY-1];
    assign LVBL_dly = r_vbl[PAL_LATENCY-1];

    // Bank select follows the CPU read so the readback mux matches the RAM data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank <= 1'b0;
        end else if (cen_E) begin
            r_bank <= cpu_AB[BANK_BIT];
        end
    end

    assign pal_dout = r_bank ? {4'hF, w_b_cq[3:0]} : w_rg_cq;

endmodule

// File: tb/tb_jtdd_colmix.sv
// Directed bench for jtdd_colmix: vector table for priority/lookup plus
// hand sequences for latency, blanking, write collision and reset.
module tb_jtdd_colmix;

    logic       clk;
    logic       rst;
    logic       pxl_cen;
    logic       cen_E;
    logic [9:0] cpu_AB;
    logic       pal_cs;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;
    logic [6:0] char_pxl;
    logic [6:0] obj_pxl;
    logic [7:0] scr_pxl;
    logic       LHBL;
    logic       LVBL;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       LHBL_dly;
    logic       LVBL_dly;

    int n_checks;
    int n_errors;

    jtdd_colmix dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .cen_E    (cen_E),
        .cpu_AB   (cpu_AB),
        .pal_cs   (pal_cs),
        .cpu_wrn  (cpu_wrn),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .scr_pxl  (scr_pxl),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  chr;
        logic [6:0]  obj;
        logic [7:0]  scr;
        logic        hb;
        logic        vb;
        logic [13:0] exp;   // {red, green, blue, LHBL_dly, LVBL_dly}
    } vec_t;

    vec_t        vecs [10];
    logic [17:0] pre  [10];  // {cpu_AB, data}

    function automatic logic [13:0] outs();
        return {red, green, blue, LHBL_dly, LVBL_dly};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            pxl_cen = 1'b1;
            @(posedge clk);
            #1;
            pxl_cen = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
        cpu_AB = a; cpu_dout = d; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
        @(posedge clk);
        #1;
        pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
    endtask

    task automatic cpu_rd(input logic [9:0] a, input string name, input logic [7:0] exp);
        cpu_AB = a; pal_cs = 1'b1; cpu_wrn = 1'b1; cen_E = 1'b1;
        @(posedge clk);
        #1;
        pal_cs = 1'b0; cen_E = 1'b0;
        check(name, {8'h00, pal_dout}, {8'h00, exp});
    endtask

    task automatic set_px(input logic [6:0] c, input logic [6:0] o, input logic [7:0] s,
                          input logic hb, input logic vb);
        char_pxl = c; obj_pxl = o; scr_pxl = s; LHBL = hb; LVBL = vb;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; pxl_cen = 1'b0; cen_E = 1'b0; cpu_AB = '0; pal_cs = 1'b0;
        cpu_wrn = 1'b1; cpu_dout = '0;
        set_px(7'h00, 7'h00, 8'h05, 1'b1, 1'b1);

        pre[0] = {10'h105, 8'h3A};  pre[1] = {10'h305, 8'h07};
        pre[2] = {10'h012, 8'h00};  pre[3] = {10'h212, 8'h05};
        pre[4] = {10'h134, 8'h5C};  pre[5] = {10'h334, 8'h09};
        pre[6] = {10'h0A3, 8'h71};  pre[7] = {10'h2A3, 8'h52};
        pre[8] = {10'h100, 8'hE4};  pre[9] = {10'h300, 8'h0B};

        vecs[0] = '{7'h00, 7'h00, 8'h05, 1'b1, 1'b1, {12'hA37, 2'b11}};
        vecs[1] = '{7'h12, 7'h23, 8'hB4, 1'b1, 1'b1, {12'h005, 2'b11}};
        vecs[2] = '{7'h10, 7'h23, 8'hB4, 1'b1, 1'b1, {12'hC59, 2'b11}};
        vecs[3] = '{7'h00, 7'h23, 8'h34, 1'b1, 1'b1, {12'h172, 2'b11}};
        vecs[4] = '{7'h00, 7'h20, 8'h34, 1'b1, 1'b1, {12'hC59, 2'b11}};
        vecs[5] = '{7'h00, 7'h00, 8'h00, 1'b1, 1'b1, {12'h4EB, 2'b11}};
        vecs[6] = '{7'h00, 7'h23, 8'h80, 1'b1, 1'b1, {12'h172, 2'b11}};
        vecs[7] = '{7'h12, 7'h23, 8'hB4, 1'b0, 1'b1, {12'h000, 2'b01}};
        vecs[8] = '{7'h00, 7'h00, 8'h05, 1'b1, 1'b0, {12'h000, 2'b10}};
        vecs[9] = '{7'h70, 7'h00, 8'h34, 1'b1, 1'b1, {12'hC59, 2'b11}};

        // Reset holds outputs low even with pixel ticks running
        idle(1);
        tick(3);
        check("reset_outputs", {2'b00, outs()}, 16'h0000);
        rst = 1'b1;
        idle(1);

        for (int i = 0; i < 10; i++) cpu_wr(pre[i][17:8], pre[i][7:0]);

        for (int i = 0; i < 10; i++) begin
            set_px(vecs[i].chr, vecs[i].obj, vecs[i].scr, vecs[i].hb, vecs[i].vb);
            tick(3);
            check($sformatf("vec%0d", i), {2'b00, outs()}, {2'b00, vecs[i].exp});
        end

        // Hold while pxl_cen=0 (with a CPU write), then three-tick latency
        set_px(7'h00, 7'h00, 8'h05, 1'b1, 1'b1);
        tick(3);
        set_px(7'h12, 7'h23, 8'hB4, 1'b1, 1'b1);
        idle(2);
        cpu_wr(10'h1FF, 8'h99);
        idle(2);
        check("hold_no_cen", {2'b00, outs()}, {2'b00, 12'hA37, 2'b11});
        tick(2);
        check("latency_t2", {2'b00, outs()}, {2'b00, 12'hA37, 2'b11});
        tick(1);
        check("latency_t3", {2'b00, outs()}, {2'b00, 12'h005, 2'b11});

        // Horizontal blank edges take exactly three ticks
        set_px(7'h00, 7'h00, 8'h05, 1'b1, 1'b1);
        tick(3);
        LHBL = 1'b0;
        tick(2);
        check("hbl_fall_t2", {2'b00, outs()}, {2'b00, 12'hA37, 2'b11});
        tick(1);
        check("hbl_fall_t3", {2'b00, outs()}, {2'b00, 12'h000, 2'b01});
        LHBL = 1'b1;
        tick(2);
        check("hbl_rise_t2", {2'b00, outs()}, {2'b00, 12'h000, 2'b01});
        tick(1);
        check("hbl_rise_t3", {2'b00, outs()}, {2'b00, 12'hA37, 2'b11});

        // CPU write on the same edge that video reads entry 0x012
        set_px(7'h12, 7'h00, 8'h00, 1'b1, 1'b1);
        tick(1);
        cpu_AB = 10'h012; cpu_dout = 8'hFF; pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
        tick(1);
        check("collide_old", {2'b00, outs()}, {2'b00, 12'h005, 2'b11});
        tick(1);
        check("collide_new", {2'b00, outs()}, {2'b00, 12'hFF5, 2'b11});

        cpu_rd(10'h012, "rd_rg_012", 8'hFF);
        cpu_rd(10'h305, "rd_b_105", 8'hF7);
        cpu_rd(10'h2A3, "rd_b_0a3", 8'hF2);
        cpu_rd(10'h1FF, "rd_rg_1ff", 8'h99);

        // Mid-line reset: immediate blanking, RAM kept, three ticks to recover
        set_px(7'h00, 7'h00, 8'h05, 1'b1, 1'b1);
        tick(3);
        rst = 1'b0;
        #2;
        check("rst_async", {2'b00, outs()}, 16'h0000);
        tick(2);
        check("rst_held", {2'b00, outs()}, 16'h0000);
        rst = 1'b1;
        cpu_rd(10'h105, "rd_after_rst", 8'h3A);
        tick(2);
        check("rst_rel_t2", {2'b00, outs()}, 16'h0000);
        tick(1);
        check("rst_rel_t3", {2'b00, outs()}, {2'b00, 12'hA37, 2'b11});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
